// File: rtl/reg_transfer_bank.sv
// Register bank with a shared transfer bus and a small sequencer that runs
// one-shot LOAD / MOVE / SWAP / CLEAR commands over that bus.
module reg_transfer_bank #(
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned NUM_REGS    = 4,
    localparam int unsigned SEL_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             op,
    input  logic [SEL_WIDTH-1:0]   src_sel,
    input  logic [SEL_WIDTH-1:0]   dst_sel,
    input  logic [WORD_LENGTH-1:0] ext_data,
    input  logic [SEL_WIDTH-1:0]   rd_sel,
    output logic [WORD_LENGTH-1:0] rd_data,
    output logic [WORD_LENGTH-1:0] bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {ST_IDLE, ST_S1, ST_S2, ST_S3, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_MOVE = 2'b01,
                              OP_SWAP = 2'b10, OP_CLEAR = 2'b11} op_t;

    state_t                 state_q, state_d;
    op_t                    op_q;
    logic [SEL_WIDTH-1:0]   src_q, dst_q;
    logic [WORD_LENGTH-1:0] data_q;
    logic [WORD_LENGTH-1:0] tmp_q;
    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];

    logic [WORD_LENGTH-1:0] src_word, dst_word;
    logic                   src_ok, dst_ok;
    logic                   wr_en, tmp_we;
    logic [SEL_WIDTH-1:0]   wr_idx;

    // Indices that match no register read as 0 and flag the command as bad.
    always_comb begin
        src_word = '0;
        dst_word = '0;
        rd_data  = '0;
        src_ok   = 1'b0;
        dst_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_WIDTH'(i)) begin
                src_word = regs_q[i];
                src_ok   = 1'b1;
            end
            if (dst_q == SEL_WIDTH'(i)) begin
                dst_word = regs_q[i];
                dst_ok   = 1'b1;
            end
            if (rd_sel == SEL_WIDTH'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    always_comb begin
        bus = '0;
        case (state_q)
            ST_S1: begin
                case (op_q)
                    OP_LOAD:          bus = data_q;
                    OP_MOVE, OP_SWAP: bus = src_word;
                    default:          bus = '0;
                endcase
            end
            ST_S2:   bus = dst_word;
            ST_S3:   bus = tmp_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        tmp_we  = 1'b0;
        wr_idx  = dst_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_S1;
            ST_S1: begin
                if (op_q == OP_SWAP) begin
                    tmp_we  = 1'b1;
                    state_d = ST_S2;
                end else begin
                    wr_en   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_S2: begin
                wr_en   = 1'b1;
                wr_idx  = src_q;
                state_d = ST_S3;
            end
            ST_S3: begin
                wr_en   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = done & (~dst_ok | (((op_q == OP_MOVE) | (op_q == OP_SWAP)) & ~src_ok));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            tmp_q   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                op_q   <= op_t'(op);
                src_q  <= src_sel;
                dst_q  <= dst_sel;
                data_q <= ext_data;
            end
            if (tmp_we) tmp_q <= bus;
            if (wr_en) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == SEL_WIDTH'(i)) regs_q[i] <= bus;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_transfer_bank.sv
// Drives a 4-register and a 3-register bank with identical directed commands
// and checks both against a transaction-level model every cycle.
module tb_reg_transfer_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = '0;
    logic [1:0] src_sel = '0;
    logic [1:0] dst_sel = '0;
    logic [7:0] ext_data = '0;
    logic [1:0] rd_sel = '0;

    logic [7:0] rd4, bus4, rd3, bus3;
    logic       busy4, done4, err4, busy3, done3, err3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_transfer_bank #(.WORD_LENGTH(8), .NUM_REGS(4)) u4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_sel(src_sel),
        .dst_sel(dst_sel), .ext_data(ext_data), .rd_sel(rd_sel),
        .rd_data(rd4), .bus(bus4), .busy(busy4), .done(done4), .err(err4));

    reg_transfer_bank #(.WORD_LENGTH(8), .NUM_REGS(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_sel(src_sel),
        .dst_sel(dst_sel), .ext_data(ext_data), .rd_sel(rd_sel),
        .rd_data(rd3), .bus(bus3), .busy(busy3), .done(done3), .err(err3));

    // Model: each accepted command expands into a list of per-cycle steps.
    typedef struct {
        logic [7:0] bus;
        bit         done;
        bit         err;
        bit         wr;
        int         idx;
        logic [7:0] val;
    } step_t;

    step_t      sch [2][5];
    int         slen [2];
    int         spos [2];
    logic [7:0] mreg [2][16];
    int         nregs [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        nregs[0] = 4;
        nregs[1] = 3;
        for (int k = 0; k < 2; k++) begin
            slen[k] = 0;
            spos[k] = 0;
            for (int i = 0; i < 16; i++) mreg[k][i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int n, s, d;
                logic [7:0] a, b;
                bit e;
                n = nregs[k];
                if (reset) begin
                    slen[k] = 0;
                    spos[k] = 0;
                    for (int i = 0; i < 16; i++) mreg[k][i] = '0;
                end else if (spos[k] < slen[k]) begin
                    if (sch[k][spos[k]].wr && sch[k][spos[k]].idx < n)
                        mreg[k][sch[k][spos[k]].idx] = sch[k][spos[k]].val;
                    spos[k]++;
                    if (spos[k] == slen[k]) begin
                        slen[k] = 0;
                        spos[k] = 0;
                    end
                end else if (start) begin
                    s = int'(src_sel);
                    d = int'(dst_sel);
                    a = (s < n) ? mreg[k][s] : 8'h00;
                    b = (d < n) ? mreg[k][d] : 8'h00;
                    e = !(d < n) || ((op == 2'd1 || op == 2'd2) && !(s < n));
                    case (op)
                        2'd0: begin sch[k][0] = '{ext_data, 0, 0, 1, d, ext_data}; slen[k] = 1; end
                        2'd1: begin sch[k][0] = '{a, 0, 0, 1, d, a}; slen[k] = 1; end
                        2'd2: begin
                            sch[k][0] = '{a, 0, 0, 0, 0, 8'h00};
                            sch[k][1] = '{b, 0, 0, 1, s, b};
                            sch[k][2] = '{a, 0, 0, 1, d, a};
                            slen[k] = 3;
                        end
                        default: begin sch[k][0] = '{8'h00, 0, 0, 1, d, 8'h00}; slen[k] = 1; end
                    endcase
                    sch[k][slen[k]] = '{8'h00, 1, e, 0, 0, 8'h00};
                    slen[k]++;
                    spos[k] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    logic [7:0] ebus, erd;
                    bit ebusy, edone, eerr;
                    ebusy = spos[k] < slen[k];
                    ebus  = ebusy ? sch[k][spos[k]].bus : 8'h00;
                    edone = ebusy ? sch[k][spos[k]].done : 1'b0;
                    eerr  = ebusy ? sch[k][spos[k]].err : 1'b0;
                    erd   = (int'(rd_sel) < nregs[k]) ? mreg[k][rd_sel] : 8'h00;
                    chk($sformatf("n%0d_busy", nregs[k]), (k == 0) ? busy4 : busy3, ebusy);
                    chk($sformatf("n%0d_done", nregs[k]), (k == 0) ? done4 : done3, edone);
                    chk($sformatf("n%0d_err", nregs[k]), (k == 0) ? err4 : err3, eerr);
                    chk($sformatf("n%0d_bus", nregs[k]), (k == 0) ? bus4 : bus3, ebus);
                    chk($sformatf("n%0d_rd", nregs[k]), (k == 0) ? rd4 : rd3, erd);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                         input logic [7:0] x);
        op = o; src_sel = s; dst_sel = d; ext_data = x; start = 1'b1;
        cycle();
        start = 1'b0;
        op = ~o; src_sel = s + 2'd1; dst_sel = d + 2'd1; ext_data = ~x;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy4 && !busy3) break;
            cycle();
        end
        chk("idle_timeout", {busy4, busy3}, 2'b00);
    endtask

    task automatic run(input logic [1:0] o, input logic [1:0] s, input logic [1:0] d,
                       input logic [7:0] x);
        issue(o, s, d, x);
        wait_idle();
    endtask

    task automatic peek(input logic [1:0] idx, input logic [7:0] e4, input logic [7:0] e3);
        rd_sel = idx;
        #1;
        chk($sformatf("peek4_r%0d", idx), rd4, e4);
        chk($sformatf("peek3_r%0d", idx), rd3, e3);
    endtask

    initial begin
        // Reset held over two edges
        cycle();
        chk_en = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_busy", {busy4, busy3}, 2'b00);
        chk("rst_bus", bus4, 8'h00);
        peek(0, 8'h00, 8'h00); peek(1, 8'h00, 8'h00);
        peek(2, 8'h00, 8'h00); peek(3, 8'h00, 8'h00);
        cycle();

        // LOAD 0xA5 -> r2
        rd_sel = 2;
        issue(2'd0, 2'd0, 2'd2, 8'hA5);
        chk("load_s1_bus", bus4, 8'hA5);
        chk("load_s1_rd", rd4, 8'h00);
        cycle();
        chk("load_done", {done4, done3}, 2'b11);
        chk("load_rd_after", rd4, 8'hA5);
        cycle();
        chk("load_idle", {busy4, done4}, 2'b00);
        peek(0, 8'h00, 8'h00); peek(1, 8'h00, 8'h00);
        peek(2, 8'hA5, 8'hA5); peek(3, 8'h00, 8'h00);

        // MOVE r1 -> r3 (out of range on the 3-register bank)
        run(2'd0, 2'd0, 2'd1, 8'h3C);
        rd_sel = 3;
        issue(2'd1, 2'd1, 2'd3, 8'h00);
        chk("move_busy1", busy4, 1'b1);
        cycle();
        chk("move_busy2", busy4, 1'b1);
        chk("move_done_err", {done4, err4, done3, err3}, 4'b1011);
        cycle();
        chk("move_busy3", busy4, 1'b0);
        peek(1, 8'h3C, 8'h3C); peek(3, 8'h3C, 8'h00);

        // SWAP r0 <-> r2
        run(2'd0, 2'd0, 2'd0, 8'h11);
        run(2'd0, 2'd0, 2'd2, 8'hEE);
        issue(2'd2, 2'd0, 2'd2, 8'h00);
        chk("swap_bus_s1", bus4, 8'h11);
        cycle();
        chk("swap_bus_s2", bus4, 8'hEE);
        cycle();
        chk("swap_bus_s3", bus3, 8'h11);
        cycle();
        chk("swap_done", {done4, done3, err4, err3}, 4'b1100);
        cycle();
        peek(0, 8'hEE, 8'hEE); peek(2, 8'h11, 8'h11);
        run(2'd2, 2'd1, 2'd1, 8'h00);
        peek(1, 8'h3C, 8'h3C);

        // Start during SWAP S2 is ignored; start in first idle cycle is accepted
        issue(2'd2, 2'd0, 2'd2, 8'h00);
        cycle();
        op = 2'd0; dst_sel = 2'd0; ext_data = 8'hFF; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("coll_s3_nodone", done4, 1'b0);
        cycle();
        chk("coll_done", done4, 1'b1);
        cycle();
        chk("coll_idle", {busy4, done4}, 2'b00);
        issue(2'd0, 2'd0, 2'd3, 8'h5A);
        chk("coll_next_accepted", busy4, 1'b1);
        wait_idle();
        peek(0, 8'h11, 8'h11); peek(3, 8'h5A, 8'h00);

        // LOAD to index 3: discarded with err on the 3-register bank
        issue(2'd0, 2'd0, 2'd3, 8'h77);
        cycle();
        chk("oor_done_err", {done4, err4, done3, err3}, 4'b1011);
        cycle();
        peek(3, 8'h77, 8'h00); peek(0, 8'h11, 8'h11);
        peek(1, 8'h3C, 8'h3C); peek(2, 8'hEE, 8'hEE);

        // Reset mid-SWAP
        issue(2'd2, 2'd0, 2'd2, 8'h00);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_mid_state", {busy4, done4, busy3, done3}, 4'b0000);
        chk("rst_mid_bus", bus4, 8'h00);
        peek(0, 8'h00, 8'h00); peek(1, 8'h00, 8'h00);
        peek(2, 8'h00, 8'h00); peek(3, 8'h00, 8'h00);

        // Reset and start together: command dropped
        op = 2'd0; dst_sel = 2'd0; ext_data = 8'h99; start = 1'b1; reset = 1'b1;
        cycle();
        start = 1'b0; reset = 1'b0;
        chk("rst_start_dropped", {busy4, busy3}, 2'b00);
        peek(0, 8'h00, 8'h00);

        // CLEAR after reset
        run(2'd0, 2'd0, 2'd1, 8'h42);
        peek(1, 8'h42, 8'h42);
        issue(2'd3, 2'd0, 2'd1, 8'h00);
        chk("clear_s1", {busy4, bus4}, {1'b1, 8'h00});
        cycle();
        chk("clear_done", {done4, err4}, 2'b10);
        cycle();
        peek(1, 8'h00, 8'h00);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_transfer_bank.md
# reg_transfer_bank

Parametrised register bank with a shared internal transfer bus and a small sequencer. It generalises the two-input data/bus selector into NUM_REGS registers of WORD_LENGTH bits that exchange data over one bus under FSM control. The block supports external load, register-to-register move, three-phase swap through a temporary register, and clear. It sits in the datapath of the register-transfer design, with the control unit issuing one-shot transfer commands.

## Interface
- WORD_LENGTH, 8, data width of every register, the bus and ext_data.
- NUM_REGS, 4, number of registers (2..16); localparam SEL_WIDTH = $clog2(NUM_REGS).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising clk edge.
- start  input  1  command strobe; accepted only in IDLE.
- op  input  2  00 LOAD, 01 MOVE, 10 SWAP, 11 CLEAR.
- src_sel  input  SEL_WIDTH  source register index (MOVE, SWAP).
- dst_sel  input  SEL_WIDTH  destination register index (all ops).
- ext_data  input  WORD_LENGTH  data for LOAD.
- rd_sel  input  SEL_WIDTH  combinational read-port index.
- rd_data  output  WORD_LENGTH  reg[rd_sel]; 0 if out of range.
- bus  output  WORD_LENGTH  current transfer-bus value; 0 outside transfer states.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in DONE state.
- err  output  1  one-cycle pulse with done if any used index ≥ NUM_REGS.

## Operation
- Edge with start=1 in IDLE: latch op, src_sel, dst_sel, ext_data into command registers; go to S1. Inputs may change afterwards.
- start outside IDLE is ignored. There is no queue.
- Bus mux:
  - S1: LOAD → latched ext_data; MOVE/SWAP → reg[src]; CLEAR → 0.
  - S2: reg[dst].
  - S3: tmp.
  - IDLE/DONE: 0.
- LOAD/MOVE/CLEAR: in S1, reg[dst] ← bus at edge; next state DONE.
- SWAP:
  - S1: tmp ← bus; go to S2.
  - S2: reg[src] ← bus; go to S3.
  - S3: reg[dst] ← bus; go to DONE.
- DONE → IDLE unconditionally. done=1 and err as computed.
- src==dst: MOVE and SWAP leave the register unchanged. The full sequence still runs with the same latency.
- Out-of-range index (NUM_REGS not a power of 2):
  - Writes to it are discarded; reads of it return 0.
  - Sequence completes normally with err=1 alongside done.
  - src is only checked for MOVE/SWAP.
- Only one register is written per cycle. The read port sees the new value the cycle after the write edge.

## Timing
- Reset values: all registers 0, tmp 0, command registers 0, state IDLE, bus 0, busy 0, done 0, err 0. rd_data is 0 after reset.
- Start sampled at edge E0:
  - LOAD/MOVE/CLEAR: write at E1; done high in the cycle after E1; busy high E0→E2. Start to done is 2 cycles.
  - SWAP: writes at E1 (tmp), E2 (src) and E3 (dst); done high in the cycle after E3. Start to done is 4 cycles.
- Earliest next accepted start is at the edge ending DONE+1, i.e. the first IDLE cycle.
- Reset mid-operation: it wins over everything. State goes to IDLE and all registers clear. No done/err pulse for the aborted command.
- reset and start in the same cycle: reset wins; the command is dropped.

## Test plan
- Reset then LOAD: WORD_LENGTH=8, NUM_REGS=4. Assert reset 2 cycles, then LOAD ext_data=0xA5 dst=2. Required: rd_data(rd_sel=2)=0xA5 from cycle E1+1; done pulse 2 cycles after start; bus=0xA5 during S1; all other registers 0.
- MOVE: with reg1=0x3C, MOVE src=1 dst=3. Required: reg3=0x3C and reg1 unchanged; busy high exactly 2 cycles; err=0.
- SWAP: with reg0=0x11 and reg2=0xEE, SWAP src=0 dst=2. Required: bus sequence 0x11, 0xEE, 0x11 over S1–S3; final reg0=0xEE and reg2=0x11; done 4 cycles after start. Also SWAP src=dst=1 leaves reg1 unchanged.
- Busy collision: issue start with LOAD 0xFF dst=0 during a SWAP's S2. Required: ignored, reg0 not modified, one done pulse only. A start in the first IDLE cycle after DONE is accepted.
- Out-of-range: NUM_REGS=3, LOAD 0x77 dst=3. Required: no register changes; done and err both pulse; rd_data(rd_sel=3)=0.
- Reset mid-SWAP: assert reset in S2. Required: next cycle busy=0, done=0, all registers 0, bus=0. A subsequent CLEAR dst=1 completes normally.
